// File: rtl/fxp8s_shift_arbiter_pkg.sv
// Shared constants and types for the FXP8S shift arbiter.
// FXP8S is 8-bit sign-magnitude: bit 7 sign, bits 6:0 magnitude.
package fxp8s_shift_arbiter_pkg;
  localparam int FXP_W     = 8;
  localparam int MAG_W     = FXP_W - 1;
  localparam int SH_W      = 3;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNT_W = 16;
  localparam int ID_W      = 2;

  typedef logic [FXP_W-1:0] fxp8s_t;

  typedef struct packed {
    fxp8s_t          data;
    fxp8s_t          shift;
    logic [ID_W-1:0] id;
  } op_t;
endpackage

// File: rtl/fxp8s_var_shifter.sv
// Variable shift of an FXP8S operand; the shift control is itself FXP8S:
// positive shifts left (saturating), negative shifts right (truncating).
module fxp8s_var_shifter
  import fxp8s_shift_arbiter_pkg::*;
(
  input  fxp8s_t data,
  input  fxp8s_t shift,
  output fxp8s_t result
);

  logic [2*MAG_W-1:0] wide;
  logic [MAG_W-1:0]   mag;
  logic [SH_W-1:0]    amt;
  logic               big;
  logic               nz;

  always_comb begin
    amt  = shift[SH_W-1:0];
    big  = |shift[MAG_W-1:SH_W];
    nz   = |data[MAG_W-1:0];
    wide = {{MAG_W{1'b0}}, data[MAG_W-1:0]} << amt;
    if (shift[FXP_W-1]) begin
      mag = big ? '0 : data[MAG_W-1:0] >> amt;
    end else if (big) begin
      mag = nz ? '1 : '0;
    end else if (|wide[2*MAG_W-1:MAG_W]) begin
      mag = '1;
    end else begin
      mag = wide[MAG_W-1:0];
    end
    // A zero magnitude never carries a sign.
    result = {data[FXP_W-1] & |mag, mag};
  end

endmodule

// File: rtl/fxp8s_shift_arbiter.sv
// Round-robin arbiter feeding a two-stage FXP8S variable-shift pipeline.
// Results leave in acceptance order; done_cnt counts output handshakes.
module fxp8s_shift_arbiter
  import fxp8s_shift_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [FXP_W*NREQ-1:0] req_data,
  input  logic [FXP_W*NREQ-1:0] req_shift,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output fxp8s_t                rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [CNT_W-1:0]      done_cnt
);

  op_t             s1;
  logic            s1_valid;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            s1_free;
  logic            s2_free;
  logic            accept;
  fxp8s_t          sh_out;

  assign s2_free = !rsp_valid | rsp_ready;
  assign s1_free = !s1_valid | s2_free;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign accept = found & s1_free & !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      ptr      <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1.data  <= req_data[winner*FXP_W +: FXP_W];
      s1.shift <= req_shift[winner*FXP_W +: FXP_W];
      s1.id    <= winner;
      ptr      <= winner + ID_W'(1);
    end else if (s1_free) begin
      s1_valid <= 1'b0;
    end
  end

  fxp8s_var_shifter u_shifter (
    .data   (s1.data),
    .shift  (s1.shift),
    .result (sh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (s2_free) begin
      rsp_valid <= s1_valid;
      rsp_data  <= sh_out;
      rsp_id    <= s1.id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp8s_shift_arbiter.sv
// Scoreboard bench for fxp8s_shift_arbiter: a negedge model pushes
// expected results on predicted accepts, a monitor pops on handshakes.
module tb_fxp8s_shift_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [31:0] req_shift;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] done_cnt;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_in [4];
  exp_t       sb_q [$];
  int         id_log [$];

  logic       s1v_m = 1'b0;
  logic       s2v_m = 1'b0;
  int         ptr_m = 0;
  logic [15:0] cnt_m = '0;

  logic       hold_prev = 1'b0;
  logic [7:0] prev_d;
  logic [1:0] prev_id;

  // Hand-computed shifter vectors: data, shift, expected result.
  logic [7:0] tv_d [12] = '{8'h05, 8'h85, 8'h40, 8'hC0, 8'h7F, 8'h83,
                            8'h26, 8'h91, 8'h01, 8'h8C, 8'h03, 8'h80};
  logic [7:0] tv_s [12] = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h83, 8'h82,
                            8'h80, 8'h84, 8'h07, 8'h8A, 8'h10, 8'h7F};
  logic [7:0] tv_e [12] = '{8'h14, 8'h8A, 8'h7F, 8'hFF, 8'h0F, 8'h00,
                            8'h26, 8'h81, 8'h7F, 8'h00, 8'h7F, 8'h00};

  fxp8s_shift_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shift (req_shift),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d,
                                           input logic [7:0] s);
    int m;
    int a;
    m = int'(d[6:0]);
    a = int'(s[6:0]);
    if (s[7]) begin
      m = (a >= 7) ? 0 : m / (1 << a);
    end else begin
      for (int k = 0; k < a && m <= 127; k++) m = m * 2;
      if (m > 127) m = 127;
    end
    return {d[7] && (m != 0), 7'(m)};
  endfunction

  task automatic set_req(input int i, input logic [7:0] d,
                         input logic [7:0] s, input logic [7:0] e);
    req_data[i*8 +: 8]  = d;
    req_shift[i*8 +: 8] = s;
    exp_in[i]           = e;
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    @(posedge clk);
    #1;
    req_valid = v;
    rsp_ready = r;
  endtask

  task automatic pulse_reset(input logic [3:0] v_during);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req_valid = v_during;
    @(negedge clk);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_done_cnt", int'(done_cnt), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
  endtask

  // Reference model: predicts grants and pipeline occupancy.
  always @(negedge clk) begin
    int   win;
    logic any;
    logic s2f;
    logic s1f;
    logic [3:0] exp_rdy;
    if (rst) begin
      chk("rst_hold_ready", int'(req_ready), 0);
      s1v_m = 1'b0;
      s2v_m = 1'b0;
      ptr_m = 0;
      cnt_m = '0;
      sb_q.delete();
    end else begin
      chk("rsp_valid", int'(rsp_valid), int'(s2v_m));
      chk("done_cnt", int'(done_cnt), int'(cnt_m));
      any = 1'b0;
      win = 0;
      for (int k = 3; k >= 0; k--) begin
        if (req_valid[(ptr_m + k) % 4]) begin
          win = (ptr_m + k) % 4;
          any = 1'b1;
        end
      end
      s2f     = !s2v_m || rsp_ready;
      s1f     = !s1v_m || s2f;
      exp_rdy = (s1f && any) ? 4'(1 << win) : 4'b0000;
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      if (s2v_m && rsp_ready) cnt_m = cnt_m + 16'd1;
      if (s2f) s2v_m = s1v_m;
      if (s1f && any) begin
        sb_q.push_back('{d: exp_in[win], id: 2'(win)});
        s1v_m = 1'b1;
        ptr_m = (win + 1) % 4;
      end else if (s1f) begin
        s1v_m = 1'b0;
      end
    end
  end

  // Monitor: pops on each output handshake, checks stalled output holds.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", int'(rsp_valid), 1);
        chk("stall_data", int'(rsp_data), int'(prev_d));
        chk("stall_id", int'(rsp_id), int'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", int'(rsp_id), -1);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", int'(rsp_data), int'(e.d));
          chk("rsp_id", int'(rsp_id), int'(e.id));
        end
        id_log.push_back(int'(rsp_id));
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_d    = rsp_data;
      prev_id   = rsp_id;
    end
  end

  initial begin
    int acc;
    logic [7:0] d;
    logic [7:0] s;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_data  = '0;
    req_shift = '0;
    for (int i = 0; i < 4; i++) exp_in[i] = '0;
    @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_done_cnt", int'(done_cnt), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester 2 streaming the hand vectors.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      set_req(2, tv_d[i], tv_s[i], tv_e[i]);
      req_valid = 4'b0100;
    end
    drive(4'b0000, 1'b1);
    repeat (3) @(posedge clk);

    // Fairness: all four valid for 12 cycles after reset.
    pulse_reset(4'b0000);
    for (int i = 0; i < 4; i++) set_req(i, tv_d[i+4], tv_s[i+4], tv_e[i+4]);
    id_log.delete();
    repeat (12) drive(4'b1111, 1'b1);
    drive(4'b0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("fair_done_cnt", int'(done_cnt), 12);
    chk("fair_count", id_log.size(), 12);
    for (int i = 0; i < 12 && i < id_log.size(); i++)
      chk("fair_id", id_log[i], i % 4);

    // Backpressure with requesters 1 and 3.
    set_req(1, tv_d[8], tv_s[8], tv_e[8]);
    set_req(3, tv_d[9], tv_s[9], tv_e[9]);
    id_log.delete();
    acc = 0;
    repeat (5) begin
      drive(4'b1010, 1'b0);
      @(negedge clk);
      acc += int'(|(req_valid & req_ready));
    end
    chk("hold_accepts", acc, 2);
    chk("hold_ready", int'(req_ready), 0);
    drive(4'b0000, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("release_count", id_log.size(), 2);
    if (id_log.size() == 2) begin
      chk("release_first", id_log[0], 1);
      chk("release_second", id_log[1], 3);
    end

    // Reset with both stages full.
    set_req(0, tv_d[0], tv_s[0], tv_e[0]);
    set_req(2, tv_d[1], tv_s[1], tv_e[1]);
    repeat (3) drive(4'b0101, 1'b0);
    pulse_reset(4'b1010);
    @(negedge clk);
    chk("post_rst_grant", int'(req_ready), 4'b0010);
    drive(4'b0000, 1'b1);
    repeat (4) @(posedge clk);

    // Counter wrap: 65537 handshakes from zero.
    pulse_reset(4'b0000);
    for (int i = 0; i < 4; i++) set_req(i, tv_d[i], tv_s[i], tv_e[i]);
    repeat (65537) drive(4'b1111, 1'b1);
    drive(4'b0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_done_cnt", int'(done_cnt), 1);

    // Sparse random traffic and backpressure.
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom);
        s = ($urandom_range(0, 1) == 1) ? 8'($urandom) & 8'h87
                                        : 8'($urandom);
        set_req(i, d, s, ref_shift(d, s));
      end
      req_valid = 4'($urandom) & 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drive(4'b0000, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
